// File: rtl/miriscv_gpr_pkg.sv
// miriscv general-purpose register file: shared types
// and default geometry for the multi-port GPR slice.
package miriscv_gpr_pkg;

  localparam int GPR_XLEN       = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int GPR_NUM_WORDS  = 2 ** GPR_ADDR_WIDTH;

  typedef logic [GPR_ADDR_WIDTH-1:0] gpr_addr_t;
  typedef logic [GPR_XLEN-1:0]       gpr_data_t;

endpackage

// File: rtl/miriscv_gpr_scoreboard.sv
// miriscv GPR busy scoreboard: one busy bit per register,
// reserved at decode, released by any write to the register.
module miriscv_gpr_scoreboard
  import miriscv_gpr_pkg::*;
#(
  parameter int ADDR_W   = GPR_ADDR_WIDTH,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     set,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_WR-1:0]        clr_en,
  input  logic [NUM_WR*ADDR_W-1:0] clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int NUM_WORDS = 2 ** ADDR_W;

  logic [NUM_WORDS-1:0] busy;
  logic [NUM_WORDS-1:0] busy_d;
  logic [NUM_WORDS-1:0] clr_hit;
  logic [NUM_WORDS-1:0] set_hit;
  logic                 set_ok;

  // register 0 can never be reserved when hardwired to zero
  always_comb begin
    set_ok = set;
    if (ZERO_REG != 0 && set_addr == '0)
      set_ok = 1'b0;
  end

  // decode releases from all write ports
  always_comb begin
    clr_hit = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (clr_en[p])
        clr_hit[clr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

  // decode the reservation
  always_comb begin
    set_hit = '0;
    if (set_ok)
      set_hit[set_addr] = 1'b1;
  end

  // a new producer issued as the old one retires keeps it busy
  always_comb begin
    busy_d = (busy & ~clr_hit) | set_hit;
  end

  // busy-bit state
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)
      busy <= '0;
    else
      busy <= busy_d;
  end

  // lookups see registered state only
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++)
      rd_busy[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/miriscv_gpr_mp.sv
// miriscv multi-port GPR file: N write / M read ports,
// optional write-to-read bypass, busy scoreboard, conflict flag.
module miriscv_gpr_mp
  import miriscv_gpr_pkg::*;
#(
  parameter int XLEN      = GPR_XLEN,
  parameter int ADDR_W    = GPR_ADDR_WIDTH,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int BYPASS_EN = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]   wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     sb_set_i,
  input  logic [ADDR_W-1:0]        sb_set_addr_i,
  output logic                     wr_conflict_o
);

  localparam int NUM_WORDS = 2 ** ADDR_W;

  logic [XLEN-1:0]   mem   [NUM_WORDS];
  logic [XLEN-1:0]   mem_d [NUM_WORDS];
  logic [ADDR_W-1:0] wa    [NUM_WR];
  logic [XLEN-1:0]   wd    [NUM_WR];
  logic [ADDR_W-1:0] ra    [NUM_RD];
  logic [NUM_WR-1:0] we;
  logic              conflict;
  logic              conflict_d;

  // split flat ports; writes to a hardwired zero reg are dropped
  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      wa[p] = wr_addr_i[p*ADDR_W +: ADDR_W];
      wd[p] = wr_data_i[p*XLEN +: XLEN];
      we[p] = wr_en_i[p];
      if (ZERO_REG != 0 && wa[p] == '0)
        we[p] = 1'b0;
    end
  end

  // split flat read addresses
  always_comb begin
    for (int k = 0; k < NUM_RD; k++)
      ra[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
  end

  // write merge: later ports overwrite, so highest index wins
  always_comb begin
    mem_d = mem;
    for (int p = 0; p < NUM_WR; p++) begin
      if (we[p])
        mem_d[wa[p]] = wd[p];
    end
  end

  // register array
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int w = 0; w < NUM_WORDS; w++)
        mem[w] <= '0;
    end else begin
      mem <= mem_d;
    end
  end

  // read ports with optional same-cycle bypass
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_o[k*XLEN +: XLEN] = mem[ra[k]];
      if (BYPASS_EN != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (we[p] && wa[p] == ra[k])
            rd_data_o[k*XLEN +: XLEN] = wd[p];
        end
      end
      if (ZERO_REG != 0 && ra[k] == '0)
        rd_data_o[k*XLEN +: XLEN] = '0;
    end
  end

  // any pair of live write ports on one address is a collision
  always_comb begin
    conflict_d = conflict;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (we[i] && we[j] && wa[i] == wa[j])
          conflict_d = 1'b1;
      end
    end
  end

  // sticky conflict flag, cleared only by reset
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)
      conflict <= 1'b0;
    else
      conflict <= conflict_d;
  end

  assign wr_conflict_o = conflict;

  miriscv_gpr_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .set      (sb_set_i),
    .set_addr (sb_set_addr_i),
    .clr_en   (we),
    .clr_addr (wr_addr_i),
    .rd_addr  (rd_addr_i),
    .rd_busy  (rd_busy_o)
  );

endmodule

// File: tb/tb_miriscv_gpr_mp.sv
// Bench for miriscv_gpr_mp: bypass and non-bypass instances
// share stimulus; expectations are queued and drained.
module tb_miriscv_gpr_mp;

  logic        clk;
  logic        arstn;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        conf;
  logic [63:0] nb_data;
  logic [1:0]  nb_busy;
  logic        nb_conf;

  int n_chk;
  int n_pass;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];

  logic [31:0] m_reg [32];
  logic        m_busy [32];
  logic        m_conf;

  miriscv_gpr_mp #(
    .NUM_RD(2), .NUM_WR(2), .BYPASS_EN(1), .ZERO_REG(1)
  ) u_dut (
    .clk_i(clk), .arstn_i(arstn),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .sb_set_i(sb_set), .sb_set_addr_i(sb_addr),
    .wr_conflict_o(conf)
  );

  miriscv_gpr_mp #(
    .NUM_RD(2), .NUM_WR(2), .BYPASS_EN(0), .ZERO_REG(1)
  ) u_nb (
    .clk_i(clk), .arstn_i(arstn),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_addr_i(rd_addr),
    .rd_data_o(nb_data), .rd_busy_o(nb_busy),
    .sb_set_i(sb_set), .sb_set_addr_i(sb_addr),
    .wr_conflict_o(nb_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] obs(int kind);
    case (kind)
      0: return rd_data[31:0];
      1: return rd_data[63:32];
      2: return {31'd0, rd_busy[0]};
      3: return {31'd0, rd_busy[1]};
      4: return {31'd0, conf};
      5: return nb_data[31:0];
      6: return nb_data[63:32];
      7: return {31'd0, nb_busy[0]};
      default: return {31'd0, nb_conf};
    endcase
  endfunction

  task automatic expect_(string tag, int kind,
                         logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.kind), e.val);
    end
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
  endtask

  task automatic wr(int p, logic [4:0] a, logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(int k, logic [4:0] a);
    rd_addr[k*5 +: 5] = a;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_conf = 1'b0;
  endtask

  function automatic logic [31:0] m_read(logic [4:0] a,
                                         bit byp);
    logic [31:0] v;
    logic [4:0]  w;
    v = m_reg[a];
    if (byp) begin
      for (int p = 0; p < 2; p++) begin
        w = wr_addr[p*5 +: 5];
        if (wr_en[p] && w != 0 && w == a)
          v = wr_data[p*32 +: 32];
      end
    end
    if (a == 0)
      v = '0;
    return v;
  endfunction

  // update the model from the driven inputs, then clock
  task automatic step();
    logic [4:0] a0;
    logic [4:0] a1;
    a0 = wr_addr[4:0];
    a1 = wr_addr[9:5];
    if (wr_en[0] && wr_en[1] && a0 == a1 && a0 != 0)
      m_conf = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p] && wr_addr[p*5 +: 5] != 0) begin
        m_reg[wr_addr[p*5 +: 5]]  = wr_data[p*32 +: 32];
        m_busy[wr_addr[p*5 +: 5]] = 1'b0;
      end
    end
    if (sb_set && sb_addr != 0)
      m_busy[sb_addr] = 1'b1;
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle();
    model_reset();
    arstn = 1'b0;
    #12;
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // 1: preload, then asynchronous reset
    wr(0, 5, 32'hCAFE0005);
    wr(1, 5, 32'hCAFE1005);
    sb_set = 1'b1; sb_addr = 5;
    step();
    wr(0, 31, 32'h3131_3131);
    step();
    rd(0, 5); rd(1, 31);
    expect_("pre_r5", 0, 32'hCAFE1005);
    expect_("pre_busy5", 2, 1);
    expect_("pre_conf", 4, 1);
    drain();
    #2;
    arstn = 1'b0;
    model_reset();
    expect_("rst_r5", 0, 0);
    expect_("rst_r31", 1, 0);
    expect_("rst_busy5", 2, 0);
    expect_("rst_busy31", 3, 0);
    expect_("rst_conf", 4, 0);
    drain();
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    idle();

    // 2: write then read; zero register
    wr(0, 3, 32'hDEADBEEF);
    step();
    rd(0, 3);
    expect_("r3", 0, 32'hDEADBEEF);
    expect_("r3_nb", 5, 32'hDEADBEEF);
    drain();
    wr(0, 0, 32'h1234);
    rd(0, 0);
    expect_("r0_byp", 0, 0);
    drain();
    step();
    rd(0, 0);
    expect_("r0", 0, 0);
    expect_("r0_nb", 5, 0);
    drain();

    // 3: same-cycle bypass vs none
    wr(0, 7, 32'hA5A5A5A5);
    rd(1, 7);
    expect_("byp7", 1, 32'hA5A5A5A5);
    expect_("nobyp7", 6, 0);
    drain();
    step();
    rd(1, 7);
    expect_("r7_nb_next", 6, 32'hA5A5A5A5);
    drain();

    // 4: collision, highest port wins, sticky flag
    expect_("conf_pre", 4, 0);
    wr(0, 9, 32'h11);
    wr(1, 9, 32'h22);
    rd(0, 9);
    expect_("byp_prio", 0, 32'h22);
    expect_("conf_same", 4, 0);
    drain();
    step();
    rd(0, 9);
    expect_("r9", 0, 32'h22);
    expect_("conf_set", 4, 1);
    expect_("conf_nb", 8, 1);
    drain();
    for (int i = 0; i < 10; i++)
      step();
    expect_("conf_hold", 4, 1);
    drain();

    // 5: scoreboard set/clear/priority
    sb_set = 1'b1; sb_addr = 12;
    step();
    rd(0, 12);
    wr(0, 12, 32'h55);
    expect_("busy12", 2, 1);
    expect_("busy12_nb", 7, 1);
    drain();
    step();
    rd(0, 12);
    expect_("busy12_clr", 2, 0);
    expect_("r12", 0, 32'h55);
    drain();
    sb_set = 1'b1; sb_addr = 12;
    wr(1, 12, 32'h66);
    step();
    rd(0, 12);
    expect_("busy12_setwin", 2, 1);
    expect_("r12b", 0, 32'h66);
    drain();

    // 6: reset mid-sequence, zero reg never busy
    wr(0, 4, 32'h44);
    sb_set = 1'b1; sb_addr = 4;
    step();
    sb_set = 1'b1; sb_addr = 6;
    step();
    rd(0, 4); rd(1, 6);
    expect_("busy4", 2, 1);
    expect_("busy6", 3, 1);
    drain();
    #2;
    arstn = 1'b0;
    model_reset();
    expect_("rst2_busy4", 2, 0);
    expect_("rst2_busy6", 3, 0);
    expect_("rst2_r4", 0, 0);
    drain();
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;
    idle();
    sb_set = 1'b1; sb_addr = 0;
    step();
    rd(0, 0);
    expect_("busy0", 2, 0);
    drain();
    wr(0, 0, 32'h1);
    wr(1, 0, 32'h2);
    step();
    expect_("conf_zero", 4, 0);
    drain();

    // random traffic against the model
    for (int i = 0; i < 80; i++) begin
      wr_en   = 2'($urandom_range(0, 3));
      wr_addr = {5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7))};
      wr_data = {$urandom(), $urandom()};
      rd_addr = {5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7))};
      sb_set  = 1'($urandom_range(0, 1));
      sb_addr = 5'($urandom_range(0, 7));
      expect_("rnd_d0", 0, m_read(rd_addr[4:0], 1));
      expect_("rnd_d1", 1, m_read(rd_addr[9:5], 1));
      expect_("rnd_nb1", 6, m_read(rd_addr[9:5], 0));
      expect_("rnd_b0", 2, {31'd0, m_busy[rd_addr[4:0]]});
      expect_("rnd_b1", 3, {31'd0, m_busy[rd_addr[9:5]]});
      expect_("rnd_conf", 4, {31'd0, m_conf});
      drain();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/miriscv_gpr_mp.md
Name: miriscv_gpr_mp

Overview:
- Multi-port, parametrised general-purpose register file for the miriscv core.
- Supports N write ports and M read ports, so dual-issue and long-latency units (LSU, MDU) can retire in parallel.
- Adds an optional write-to-read bypass and a per-register busy scoreboard. Decode uses the scoreboard to detect RAW hazards against in-flight long-latency results.
- Sits between decode (read, reserve) and writeback (write, release).

Parameters:
- XLEN, 32, data width.
- ADDR_W, 5, register address width; NUM_WORDS = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..3).
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to matching reads.
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  asynchronous active-low reset
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR x ADDR_W  write addresses
- wr_data_i  in  NUM_WR x XLEN  write data
- rd_addr_i  in  NUM_RD x ADDR_W  read addresses
- rd_data_o  out  NUM_RD x XLEN  read data (combinational)
- rd_busy_o  out  NUM_RD  busy bit of the addressed register (combinational)
- sb_set_i  in  1  reserve a register for a pending write
- sb_set_addr_i  in  ADDR_W  register to reserve
- wr_conflict_o  out  1  sticky flag: two write ports hit the same address in one cycle

Behaviour:
- Reset (arstn_i low, asynchronous):
  - all registers = 0, all busy bits = 0, wr_conflict_o = 0.
  - rd_data_o therefore reads 0 and rd_busy_o reads 0 immediately.
  - Reset mid-operation discards all pending reservations.
- Write:
  - on posedge clk_i, each port with wr_en_i=1 stores wr_data_i into wr_addr_i.
  - Write latency is 1 cycle to array visibility.
- Write collision: two or more enabled ports with equal address in the same cycle.
  - The highest-index port wins.
  - wr_conflict_o is set on the next edge and held until reset.
- Read: rd_data_o[k] is a combinational function of rd_addr_i[k] and the array, in the same cycle.
- Bypass (BYPASS_EN=1):
  - if any enabled write port targets rd_addr_i[k] in the current cycle, rd_data_o[k] = that wr_data_i, highest-index port first.
  - BYPASS_EN=0: the old value is returned; the new value is visible the next cycle.
- Zero register (ZERO_REG=1):
  - writes to address 0 are dropped and never bypassed.
  - reads of address 0 return 0.
  - sb_set_i to address 0 is ignored.
  - A write to address 0 never participates in the collision check.
- Scoreboard (one busy bit per register):
  - set: sb_set_i=1 sets busy[sb_set_addr_i] on the next edge.
  - clear: any enabled write to address a clears busy[a] on the next edge.
  - simultaneous set and clear of the same address: set wins, because a new producer was issued as the old one retires.
  - rd_busy_o[k] = busy[rd_addr_i[k]], registered state only; it is not cleared early by a same-cycle write.
  - A write to a non-busy register is legal and leaves busy at 0.
- Address width: addresses are full ADDR_W, so out-of-range addresses are impossible.

Decomposition:
- miriscv_gpr_pkg holds:
  - GPR_ADDR_WIDTH, default 5.
  - GPR_NUM_WORDS.
  - typedef gpr_addr_t, logic [GPR_ADDR_WIDTH-1:0].
  - typedef gpr_data_t, logic [XLEN-1:0].
- Sub-module miriscv_gpr_scoreboard holds:
  - busy-bit array and set/clear priority logic.
  - NUM_RD busy lookups.
- The top level holds the array, the write-port priority merge, the bypass mux and the conflict detector.

Test Plan:
1. Reset with registers preloaded: after reset, reading addr 5 and addr 31 -> rd_data_o = 0, rd_busy_o = 0, wr_conflict_o = 0.
2. Write 0xDEADBEEF to addr 3, then read addr 3 on the next cycle -> 0xDEADBEEF. Write 0x1234 to addr 0, then read addr 0 -> 0.
3. BYPASS_EN=1: write 0xA5A5A5A5 to addr 7 while reading addr 7 on port 1 in the same cycle -> 0xA5A5A5A5 in that cycle. With BYPASS_EN=0 the same stimulus -> old value 0.
4. NUM_WR=2: port0 writes 0x11 to addr 9 and port1 writes 0x22 to addr 9 in one cycle -> addr 9 = 0x22, wr_conflict_o = 1 from the next cycle onward, still 1 after 10 idle cycles.
5. sb_set_i to addr 12:
   - next cycle, read addr 12 -> rd_busy_o = 1.
   - write to addr 12 -> busy = 0 the cycle after.
   - sb_set_i and a write to addr 12 in the same cycle -> busy stays 1.
6. Set busy on addrs 4 and 6, then assert arstn_i low mid-sequence -> busy bits and data are 0 immediately. sb_set_i to addr 0 -> rd_busy_o for addr 0 stays 0.
